keystream_stat_monitor: RTL
===========================

// Module: keystream_stat_monitor
// PURPOSE
//  Hardware consumer of the Grain keystream: samples main_output serially over a fixed window and
//  accumulates monobit (0/1) and overlapping-pair (00/01/10/11) counts on-chip. Sits beside the
//  Grain core in the top level; replaces file-based bias checks with registered result counters
//  plus a pass flag for a balance test.
// PARAMETERS
//  WINDOW   1000  keystream bits per measurement window (>=2)
//  CNT_W    16    counter width; must satisfy 2**CNT_W > WINDOW
//  THRESH   64    max allowed |count_1 - count_0| for pass=1
// PORTS
//  Clk        in   1      system clock, all logic on rising edge
//  reset      in   1      synchronous, active-low; one clock, sync reset active-low
//  start      in   1      pulse: clear counters and begin a window (ignored while busy)
//  bit_valid  in   1      bit_in carries a keystream bit this cycle (tie to Grain shift_en)
//  bit_in     in   1      keystream bit (Grain main_output)
//  busy       out  1      window in progress
//  done       out  1      results valid; held until next start
//  pass       out  1      balance test result, valid when done=1
//  count_0    out  CNT_W  number of 0 bits in window
//  count_1    out  CNT_W  number of 1 bits in window
//  count_00/01/10/11 out CNT_W  overlapping pair counts, pair = {previous bit, current bit}
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state IDLE; busy=0, done=0, pass=0, all counts=0, have_prev=0.
//  - FSM: IDLE -start-> RUN; RUN -(WINDOW-th accepted bit)-> DONE; DONE -start-> RUN.
//    start in RUN is ignored (no restart mid-window).
//  - IDLE/DONE + start: next cycle counts=0, have_prev=0, bit_cnt=0, busy=1, done=0, pass=0.
//    bit_valid in the start cycle itself is NOT sampled.
//  - RUN, bit_valid=1: count_0 or count_1 increments; if have_prev=1, the pair {prev,bit_in}
//    counter increments; prev<=bit_in, have_prev<=1, bit_cnt++. bit_valid=0: nothing changes.
//  - First bit of a window forms no pair: count_00+01+10+11 == WINDOW-1 at done;
//    count_0+count_1 == WINDOW.
//  - Completion: on the cycle the WINDOW-th bit is accepted, counters update and next cycle
//    busy=0, done=1, pass=(|count_1-count_0| <= THRESH) computed from final counts (1-cycle latency,
//    pass and done rise together). Bits arriving in DONE/IDLE are discarded; counts frozen.
//  - Difference computed in CNT_W+1 signed bits; no counter can wrap given 2**CNT_W > WINDOW.
//  - reset low mid-window aborts: all outputs return to reset values next edge.
//  - start and final bit in same cycle while RUN: final bit taken, start ignored.
// STRUCTURE
//  - Shared package grain_pkg: typedef enum logic[1:0] {ST_IDLE, ST_RUN, ST_DONE} mon_state_t;
//    default WINDOW/CNT_W constants shared with the Grain top and bench.
//  - Sub-module pair_counter (one instance): 4 CNT_W counters indexed by {prev,bit}, with
//    clear and enable; monobit counters and FSM stay in the top module.
// TESTING
//  - Reset: hold reset=0 3 cycles with bit_valid=1 -> all counts 0, busy=0, done=0, pass=0.
//  - WINDOW=8, stream 1,0,1,1,0,0,0,1 -> count_1=4, count_0=4, 01=2, 10=2, 11=1, 00=2, pass=1.
//  - WINDOW=8, THRESH=2, all ones -> count_1=8, count_11=7, other pairs 0, pass=0.
//  - Gapped bit_valid (every 3rd cycle) over WINDOW=8 -> counts identical to contiguous case;
//    done exactly 1 cycle after 8th valid bit.
//  - start pulsed mid-window, then reset=0 mid-window -> start ignored; reset clears all outputs.
//  - Default params driven by Grain (seeds 80'h123456789ABCDEF12345, 24'h9a172d) -> count_0+count_1
//    =1000, pair sum=999, counts match software model of the same keystream.

Source files
------------

// File: rtl/grain_pkg.sv
// Shared definitions for the Grain keystream top level and its on-chip consumers.
// Holds the statistics monitor state type and the default measurement geometry.
package grain_pkg;

   // Statistics monitor control states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } mon_state_t;

   // Default window geometry shared by the Grain top and the bench
   localparam int unsigned DEF_WINDOW = 1000;
   localparam int unsigned DEF_CNT_W  = 16;
   localparam int unsigned DEF_THRESH = 64;

endpackage

// File: rtl/keystream_stat_monitor_pair_counter.sv
// Overlapping-pair counters for the keystream statistics monitor.
// Four CNT_W-bit counters indexed by {previous bit, current bit}.
// Ports:
//   Clk      in   clock, rising edge
//   reset    in   synchronous active-low reset
//   clr      in   clear all four counters
//   en       in   increment the counter selected by idx
//   idx      in   pair index {prev, bit}
//   count_00/01/10/11 out  registered pair counts
module pair_counter
   import grain_pkg::*;
#(
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic             Clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic [1:0]       idx,
   output logic [CNT_W-1:0] count_00,
   output logic [CNT_W-1:0] count_01,
   output logic [CNT_W-1:0] count_10,
   output logic [CNT_W-1:0] count_11
);

   logic [CNT_W-1:0] cnt_q [4];

   // Counter bank: clear has priority over increment
   always_ff @(posedge Clk) begin
      if (!reset || clr) begin
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= '0;
         end
      end else if (en) begin
         cnt_q[idx] <= cnt_q[idx] + CNT_W'(1);
      end
   end

   assign count_00 = cnt_q[0];
   assign count_01 = cnt_q[1];
   assign count_10 = cnt_q[2];
   assign count_11 = cnt_q[3];

endmodule

// File: rtl/keystream_stat_monitor.sv
// Keystream statistics monitor: samples WINDOW keystream bits and accumulates
// monobit and overlapping-pair counts, then flags a monobit balance test.
// Ports:
//   Clk        in   clock, rising edge
//   reset      in   synchronous active-low reset
//   start      in   clear counters and begin a window (ignored while busy)
//   bit_valid  in   bit_in carries a keystream bit this cycle
//   bit_in     in   keystream bit
//   busy       out  window in progress
//   done       out  results valid, held until next start
//   pass       out  |count_1 - count_0| <= THRESH, valid with done
//   count_0/1  out  monobit counts
//   count_00/01/10/11 out  overlapping pair counts, pair = {prev, bit}
module keystream_stat_monitor
   import grain_pkg::*;
#(
   parameter int unsigned WINDOW = DEF_WINDOW,
   parameter int unsigned CNT_W  = DEF_CNT_W,
   parameter int unsigned THRESH = DEF_THRESH
) (
   input  logic             Clk,
   input  logic             reset,
   input  logic             start,
   input  logic             bit_valid,
   input  logic             bit_in,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] count_0,
   output logic [CNT_W-1:0] count_1,
   output logic [CNT_W-1:0] count_00,
   output logic [CNT_W-1:0] count_01,
   output logic [CNT_W-1:0] count_10,
   output logic [CNT_W-1:0] count_11
);

   mon_state_t       state_q, state_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0] c0_q, c0_d;
   logic [CNT_W-1:0] c1_q, c1_d;
   logic             prev_q, prev_d;
   logic             have_prev_q, have_prev_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;

   logic             pair_clr_c;
   logic             pair_en_c;
   logic [CNT_W-1:0] nxt_c0_c, nxt_c1_c;
   logic [CNT_W:0]   diff_c, mag_c;
   logic             pass_c;
   logic             last_c;

   // Monobit counts after accepting bit_in, and the balance verdict on them
   always_comb begin
      nxt_c0_c = c0_q + CNT_W'(!bit_in);
      nxt_c1_c = c1_q + CNT_W'(bit_in);
      diff_c   = {1'b0, nxt_c1_c} - {1'b0, nxt_c0_c};
      mag_c    = diff_c[CNT_W] ? (~diff_c + (CNT_W+1)'(1)) : diff_c;
      pass_c   = (mag_c <= (CNT_W+1)'(THRESH));
      last_c   = (bit_cnt_q == CNT_W'(WINDOW - 1));
   end

   // Next-state and datapath control
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      c0_d        = c0_q;
      c1_d        = c1_q;
      prev_d      = prev_q;
      have_prev_d = have_prev_q;
      busy_d      = busy_q;
      done_d      = done_q;
      pass_d      = pass_q;
      pair_clr_c  = 1'b0;
      pair_en_c   = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            // bit_valid in the start cycle is deliberately not sampled
            if (start) begin
               state_d     = ST_RUN;
               bit_cnt_d   = '0;
               c0_d        = '0;
               c1_d        = '0;
               have_prev_d = 1'b0;
               busy_d      = 1'b1;
               done_d      = 1'b0;
               pass_d      = 1'b0;
               pair_clr_c  = 1'b1;
            end
         end
         ST_RUN: begin
            // start is ignored here; a window always runs to completion
            if (bit_valid) begin
               c0_d        = nxt_c0_c;
               c1_d        = nxt_c1_c;
               pair_en_c   = have_prev_q;
               prev_d      = bit_in;
               have_prev_d = 1'b1;
               bit_cnt_d   = bit_cnt_q + CNT_W'(1);
               if (last_c) begin
                  state_d = ST_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = pass_c;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
         end
      endcase
   end

   // State and result registers
   always_ff @(posedge Clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         c0_q        <= '0;
         c1_q        <= '0;
         prev_q      <= 1'b0;
         have_prev_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         c0_q        <= c0_d;
         c1_q        <= c1_d;
         prev_q      <= prev_d;
         have_prev_q <= have_prev_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
      end
   end

   pair_counter #(
      .CNT_W (CNT_W)
   ) u_pair_counter (
      .Clk      (Clk),
      .reset    (reset),
      .clr      (pair_clr_c),
      .en       (pair_en_c),
      .idx      ({prev_q, bit_in}),
      .count_00 (count_00),
      .count_01 (count_01),
      .count_10 (count_10),
      .count_11 (count_11)
   );

   assign busy    = busy_q;
   assign done    = done_q;
   assign pass    = pass_q;
   assign count_0 = c0_q;
   assign count_1 = c1_q;

endmodule
